// File: rtl/control_suma.sv
// Keypad sequencer for the 12-bit adder: builds two decimal operands, fires a
// one-cycle add command, waits for the adder and holds the sum for display.
module control_suma #(
  parameter int MAX_DIGITS = 3,
  parameter int RES_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [12:0] resultado,
  output logic [11:0] num1,
  output logic [11:0] num2,
  output logic        suma_btn,
  output logic [12:0] disp_value,
  output logic        busy,
  output logic [1:0]  op_sel
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int WW = $clog2(RES_LAT + 1);
  localparam logic [CW-1:0] MAXD = CW'(MAX_DIGITS);

  localparam logic [2:0] S_OP1  = 3'd0;
  localparam logic [2:0] S_OP2  = 3'd1;
  localparam logic [2:0] S_SUM  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_SHOW = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [11:0]   num1_q, num1_d;
  logic [11:0]   num2_q, num2_d;
  logic [12:0]   result_q, result_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [WW-1:0] wait_q, wait_d;

  logic isDigit, isPlus, isEq, isClr;

  assign isDigit = key_valid && (key_code <= 4'd9);
  assign isPlus  = key_valid && (key_code == 4'hA);
  assign isEq    = key_valid && (key_code == 4'hB);
  assign isClr   = key_valid && (key_code == 4'hC);

  // x*10 + d as (x<<3)+(x<<1)+d; operands never exceed 999 so 12 bits suffice
  function automatic logic [11:0] mulAdd10(input logic [11:0] x, input logic [3:0] d);
    return {x[8:0], 3'b000} + {x[10:0], 1'b0} + {8'd0, d};
  endfunction

  always_comb begin
    state_d  = state_q;
    num1_d   = num1_q;
    num2_d   = num2_q;
    result_d = result_q;
    dcnt_d   = dcnt_q;
    wait_d   = wait_q;
    if (isClr) begin
      state_d  = S_OP1;
      num1_d   = '0;
      num2_d   = '0;
      result_d = '0;
      dcnt_d   = '0;
      wait_d   = '0;
    end else begin
      case (state_q)
        S_OP1: begin
          if (isDigit && (dcnt_q < MAXD)) begin
            num1_d = mulAdd10(num1_q, key_code);
            dcnt_d = dcnt_q + CW'(1);
          end else if (isPlus) begin
            state_d = S_OP2;
            dcnt_d  = '0;
          end
        end
        S_OP2: begin
          if (isDigit && (dcnt_q < MAXD)) begin
            num2_d = mulAdd10(num2_q, key_code);
            dcnt_d = dcnt_q + CW'(1);
          end else if (isEq) begin
            state_d = S_SUM;
          end
        end
        S_SUM: begin
          wait_d  = WW'(RES_LAT);
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == '0) begin
            result_d = resultado;
            state_d  = S_SHOW;
          end else begin
            wait_d = wait_q - WW'(1);
          end
        end
        S_SHOW: begin
          // A digit after a result starts a fresh calculation; the sum is not reused
          if (isDigit) begin
            num1_d  = {8'd0, key_code};
            num2_d  = '0;
            dcnt_d  = CW'(1);
            state_d = S_OP1;
          end
        end
        default: state_d = S_OP1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_OP1;
      num1_q   <= '0;
      num2_q   <= '0;
      result_q <= '0;
      dcnt_q   <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      num1_q   <= num1_d;
      num2_q   <= num2_d;
      result_q <= result_d;
      dcnt_q   <= dcnt_d;
      wait_q   <= wait_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset drops them at once
  assign suma_btn = (state_q == S_SUM);
  assign busy     = (state_q == S_SUM) || (state_q == S_WAIT);
  assign num1     = num1_q;
  assign num2     = num2_q;

  always_comb begin
    op_sel     = 2'd0;
    disp_value = {1'b0, num1_q};
    case (state_q)
      S_OP2, S_SUM, S_WAIT: begin
        op_sel     = 2'd1;
        disp_value = {1'b0, num2_q};
      end
      S_SHOW: begin
        op_sel     = 2'd2;
        disp_value = result_q;
      end
      default: begin
        op_sel     = 2'd0;
        disp_value = {1'b0, num1_q};
      end
    endcase
  end

endmodule

// File: tb/tb_control_suma.sv
// Bench for control_suma: directed and random key sequences against a decimal
// calculator model; a monitor scores every add pulse and the displayed result.
module tb_control_suma;

  localparam int RES_LAT = 2;
  localparam int P_OP1  = 0;
  localparam int P_OP2  = 1;
  localparam int P_BUSY = 2;
  localparam int P_SHOW = 3;

  logic        clk;
  logic        rst;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic [12:0] resultado;
  logic [11:0] num1, num2;
  logic        sumaBtn;
  logic [12:0] dispValue;
  logic        busy;
  logic [1:0]  opSel;

  typedef struct {
    int n1;
    int n2;
    int sum;
    bit cancel;
  } expT;

  expT scoreQ[$];
  int  errors = 0;
  int  checks = 0;

  int  m1, m2, c1, c2, mPhase, mRes, mPending;

  control_suma #(.MAX_DIGITS(3), .RES_LAT(RES_LAT)) dut (
    .clk(clk), .rst(rst), .key_valid(keyValid), .key_code(keyCode),
    .resultado(resultado), .num1(num1), .num2(num2), .suma_btn(sumaBtn),
    .disp_value(dispValue), .busy(busy), .op_sel(opSel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder stand-in: registers the sum on the add command (one-cycle latency)
  always @(posedge clk or negedge rst) begin
    if (!rst) resultado <= 13'd0;
    else if (sumaBtn) resultado <= {1'b0, num1} + {1'b0, num2};
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m1 = 0; m2 = 0; c1 = 0; c2 = 0; mPhase = P_OP1;
  endtask

  // Calculator behaviour in plain decimal terms
  task automatic modelKey(input logic [3:0] code);
    int d;
    d = int'(code);
    if (code == 4'hC) begin
      if (mPhase == P_BUSY && scoreQ.size() > 0) scoreQ[scoreQ.size()-1].cancel = 1'b1;
      modelReset();
    end else if (d <= 9) begin
      case (mPhase)
        P_OP1:  if (c1 < 3) begin m1 = m1 * 10 + d; c1++; end
        P_OP2:  if (c2 < 3) begin m2 = m2 * 10 + d; c2++; end
        P_SHOW: begin m1 = d; c1 = 1; m2 = 0; c2 = 0; mPhase = P_OP1; end
        default: ;
      endcase
    end else if (code == 4'hA && mPhase == P_OP1) begin
      mPhase = P_OP2; c2 = 0;
    end else if (code == 4'hB && mPhase == P_OP2) begin
      expT e;
      e.n1 = m1; e.n2 = m2; e.sum = m1 + m2; e.cancel = 1'b0;
      scoreQ.push_back(e);
      mPending = m1 + m2;
      mPhase = P_BUSY;
    end
  endtask

  task automatic checkState();
    int expSel, expDisp;
    expSel  = (mPhase == P_OP1) ? 0 : (mPhase == P_OP2) ? 1 : 2;
    expDisp = (mPhase == P_OP1) ? m1 : (mPhase == P_OP2) ? m2 : mRes;
    checkOutput("num1", num1, m1);
    checkOutput("num2", num2, m2);
    checkOutput("opSel", opSel, expSel);
    checkOutput("dispValue", dispValue, expDisp);
  endtask

  // Called one step after a clock edge; presents a key for exactly one edge
  task automatic applyStimulus(input logic [3:0] code);
    keyValid = 1'b1;
    keyCode  = code;
    modelKey(code);
    @(posedge clk);
    #1;
    keyValid = 1'b0;
    keyCode  = 4'h0;
    if (mPhase != P_BUSY) checkState();
  endtask

  task automatic waitResult();
    repeat (RES_LAT + 3) @(posedge clk);
    #1;
    if (mPhase == P_BUSY) begin
      mPhase = P_SHOW;
      mRes   = mPending;
    end
    checkState();
  endtask

  task automatic pressDigits(input int value, input int count);
    int p;
    p = 1;
    for (int i = 1; i < count; i++) p = p * 10;
    for (int i = 0; i < count; i++) begin
      applyStimulus(4'((value / p) % 10));
      p = p / 10;
    end
  endtask

  // Monitor: every add pulse must match the oldest expected calculation
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && sumaBtn === 1'b1) begin
        if (scoreQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpectedPulse: got suma_btn=1 expected 0 at %0t", $time);
        end else begin
          e = scoreQ.pop_front();
          checkOutput("pulseNum1", num1, e.n1);
          checkOutput("pulseNum2", num2, e.n2);
          checkOutput("pulseBusy", busy, 1);
          for (int k = 1; k <= RES_LAT + 2; k++) begin
            @(negedge clk);
            if (k == 1) checkOutput("pulseWidth", sumaBtn, 0);
            if (!e.cancel) begin
              checkOutput("holdNum1", num1, e.n1);
              checkOutput("holdNum2", num2, e.n2);
              if (k <= RES_LAT + 1) begin
                checkOutput("busyWait", busy, 1);
                checkOutput("notShownEarly", opSel == 2'd2, 0);
              end else begin
                checkOutput("resultOpSel", opSel, 2);
                checkOutput("resultValue", dispValue, e.sum);
                checkOutput("resultBusy", busy, 0);
              end
            end else if (k == RES_LAT + 2) begin
              checkOutput("cancelBusy", busy, 0);
              checkOutput("cancelOpSel", opSel, 0);
              checkOutput("cancelDisp", dispValue, 0);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] junk;
    int nd1, nd2;
    rst = 1'b0; keyValid = 1'b0; keyCode = 4'h0;
    mRes = 0; mPending = 0;
    modelReset();
    #12;
    checkOutput("rstNum1", num1, 0);
    checkOutput("rstNum2", num2, 0);
    checkOutput("rstBtn", sumaBtn, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDisp", dispValue, 0);
    checkOutput("rstOpSel", opSel, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed: 999+999");
    pressDigits(999, 3); applyStimulus(4'hA);
    pressDigits(999, 3); applyStimulus(4'hB);
    waitResult();

    $display("[TB] directed: 800+300 then new entry");
    pressDigits(800, 3); applyStimulus(4'hA);
    pressDigits(300, 3); applyStimulus(4'hB);
    waitResult();
    applyStimulus(4'd5);

    $display("[TB] directed: fourth digit ignored, empty second operand");
    applyStimulus(4'hC);
    pressDigits(1234, 4); applyStimulus(4'hA); applyStimulus(4'hB);
    waitResult();

    $display("[TB] directed: empty first operand");
    applyStimulus(4'hC);
    applyStimulus(4'hA);
    pressDigits(600, 3); applyStimulus(4'hB);
    waitResult();

    $display("[TB] directed: digit dropped while busy");
    applyStimulus(4'd5); applyStimulus(4'hA); applyStimulus(4'd5); applyStimulus(4'hB);
    applyStimulus(4'd7);
    checkOutput("dropNum1", num1, 5);
    waitResult();

    $display("[TB] directed: clear during add");
    applyStimulus(4'd5); applyStimulus(4'hA); applyStimulus(4'd5); applyStimulus(4'hB);
    applyStimulus(4'hC);
    checkOutput("clearBusy", busy, 0);
    waitResult();

    $display("[TB] directed: asynchronous reset mid-entry");
    applyStimulus(4'd4); applyStimulus(4'd5);
    #3 rst = 1'b0;
    #1;
    modelReset();
    checkOutput("asyncNum1", num1, 0);
    checkOutput("asyncOpSel", opSel, 0);
    checkOutput("asyncDisp", dispValue, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    applyStimulus(4'd7); applyStimulus(4'hA); applyStimulus(4'd1); applyStimulus(4'hB);
    waitResult();

    $display("[TB] random sequences");
    for (int t = 0; t < 25; t++) begin
      nd1 = $urandom_range(0, 4);
      nd2 = $urandom_range(0, 4);
      if ((mPhase == P_SHOW && nd1 == 0) || $urandom_range(0, 5) == 0) applyStimulus(4'hC);
      for (int i = 0; i < nd1; i++) begin
        applyStimulus(4'($urandom_range(0, 9)));
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: junk = 4'hB;
            1: junk = 4'hD;
            2: junk = 4'hE;
            default: junk = 4'hF;
          endcase
          applyStimulus(junk);
        end
      end
      applyStimulus(4'hA);
      for (int i = 0; i < nd2; i++) begin
        applyStimulus(4'($urandom_range(0, 9)));
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: junk = 4'hA;
            1: junk = 4'hD;
            2: junk = 4'hE;
            default: junk = 4'hF;
          endcase
          applyStimulus(junk);
        end
      end
      applyStimulus(4'hB);
      if ($urandom_range(0, 6) == 0) applyStimulus(4'hC);
      waitResult();
    end

    repeat (5) @(posedge clk);
    #1;
    checkOutput("queueDrained", scoreQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
